// File: rtl/rv32i_mem_arbiter_if.sv
// Request/grant and memory-side signals shared between the rv32i core ports,
// the arbiter and the single-port memory.
interface rv32i_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic [31:0] m_rdata;

  // Arbiter side: masters the memory bus, serves both core ports.
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_be
  );

  // Environment side: core request ports plus the memory.
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data arbiter in front of one shared single-port memory.
// Data wins contested cycles unless fetch has lost STARVE_LIMIT times in a row;
// a presented request is held until the memory accepts it.
module rv32i_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv32i_mem_arbiter_if.master   bus,
  output logic                  core_stall,
  output logic [CNT_W-1:0]      perf_conflicts
);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            sel;
  logic [3:0]        starve_q, starve_d;
  logic [CNT_W-1:0]  conf_q, conf_d;
  logic              both_req;

  assign both_req = bus.i_req & bus.d_req;

  // Pick the requester presented to memory this cycle.
  always_comb begin
    sel = OWN_NONE;
    case (state_q)
      HOLD_I: if (bus.i_req) sel = OWN_I;
      HOLD_D: if (bus.d_req) sel = OWN_D;
      default: begin
        if (both_req)        sel = (starve_q == LIMIT) ? OWN_I : OWN_D;
        else if (bus.i_req)  sel = OWN_I;
        else if (bus.d_req)  sel = OWN_D;
      end
    endcase
    if (!rst_n) sel = OWN_NONE;
  end

  // Steer the winner onto the memory bus and raise its grant.
  always_comb begin
    bus.m_req   = (sel != OWN_NONE);
    bus.m_we    = (sel == OWN_D) & bus.d_we;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_be    = '0;
    if (sel == OWN_D) begin
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
      bus.m_be    = bus.d_be;
    end else if (sel == OWN_I) begin
      bus.m_addr  = bus.i_addr;
      bus.m_be    = 4'hF;
    end
    bus.i_gnt = (sel == OWN_I) & bus.m_ready;
    bus.d_gnt = (sel == OWN_D) & bus.m_ready;
  end

  // Read data is shared; only the valid flags follow the recorded owner.
  assign bus.i_rdata    = bus.m_rdata;
  assign bus.d_rdata    = bus.m_rdata;
  assign bus.i_rvalid   = (owner_q == OWN_I);
  assign bus.d_rvalid   = (owner_q == OWN_D);
  assign perf_conflicts = conf_q;

  // Freeze the core while a request waits or a data read has not returned.
  always_comb begin
    core_stall = (bus.i_req & ~bus.i_gnt) | (bus.d_req & ~bus.d_gnt) |
                 (bus.d_gnt & ~bus.d_we & ~bus.d_rvalid);
  end

  // Next-state for hold state, fairness counter, read owner and perf counter.
  always_comb begin
    state_d = IDLE;
    if (!bus.m_ready) begin
      if (sel == OWN_I) state_d = HOLD_I;
      if (sel == OWN_D) state_d = HOLD_D;
    end

    starve_d = starve_q;
    if (!bus.i_req || bus.i_gnt)                      starve_d = '0;
    else if (both_req && bus.d_gnt && starve_q < LIMIT) starve_d = starve_q + 4'd1;

    owner_d = OWN_NONE;
    if (bus.i_gnt)                    owner_d = OWN_I;
    else if (bus.d_gnt && !bus.d_we)  owner_d = OWN_D;

    conf_d = conf_q;
    if (both_req && conf_q != '1) conf_d = conf_q + 1'b1;
  end

  // State registers; reset drops any in-flight read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      conf_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      conf_q   <= conf_d;
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: directed vector table, hand-written
// hold/starvation/reset/saturation sequences, then random traffic vs. a model.
module tb_rv32i_mem_arbiter;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = 8;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_stall;
  logic [CW-1:0] perf_conflicts;
  int            n_chk = 0;
  int            n_fail = 0;

  rv32i_mem_arbiter_if bus();

  rv32i_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .core_stall(core_stall), .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir; logic [31:0] ia; logic dr; logic dwe; logic [31:0] da; logic [3:0] dbe; logic mr;
    logic gi; logic gd; logic mreq; logic mwe; logic [31:0] maddr; logic [3:0] mbe;
    logic stall; logic irv; logic drv; logic [31:0] rdata; logic [7:0] conf;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                       input logic mr);
    bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_we = dwe;
    bus.d_addr = da; bus.d_wdata = dwd; bus.d_be = dbe; bus.m_ready = mr;
  endtask

  // Memory: returns data one cycle after whatever read it accepted.
  task automatic step();
    logic [31:0] nxt;
    nxt = (bus.m_req && bus.m_ready && !bus.m_we) ? memf(bus.m_addr) : $urandom;
    @(posedge clk); #1;
    bus.m_rdata = nxt;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state: held requester, fairness count, conflict count,
  // pending read return owner and its data.
  int          mh, ms, mc, mown;
  logic [31:0] mrd;

  task automatic mdl_cycle(output logic egi, output logic egd);
    int          sel;
    logic        estall;
    logic [31:0] ea;
    if (mh == 1)                        sel = bus.i_req ? 1 : 0;
    else if (mh == 2)                   sel = bus.d_req ? 2 : 0;
    else if (bus.i_req && bus.d_req)    sel = (ms == LIMIT) ? 1 : 2;
    else if (bus.i_req)                 sel = 1;
    else if (bus.d_req)                 sel = 2;
    else                                sel = 0;
    egi = (sel == 1) && bus.m_ready;
    egd = (sel == 2) && bus.m_ready;
    ea  = (sel == 1) ? bus.i_addr : bus.d_addr;
    chk("rnd_i_gnt", 32'(bus.i_gnt), 32'(egi));
    chk("rnd_d_gnt", 32'(bus.d_gnt), 32'(egd));
    chk("rnd_m_req", 32'(bus.m_req), 32'(sel != 0));
    if (sel != 0) begin
      chk("rnd_m_addr", bus.m_addr, ea);
      chk("rnd_m_we", 32'(bus.m_we), 32'((sel == 2) && bus.d_we));
      chk("rnd_m_be", 32'(bus.m_be), (sel == 1) ? 32'hF : 32'(bus.d_be));
      if (sel == 2 && bus.d_we) chk("rnd_m_wdata", bus.m_wdata, bus.d_wdata);
    end
    chk("rnd_i_rvalid", 32'(bus.i_rvalid), 32'(mown == 1));
    chk("rnd_d_rvalid", 32'(bus.d_rvalid), 32'(mown == 2));
    if (mown == 1) chk("rnd_i_rdata", bus.i_rdata, mrd);
    if (mown == 2) chk("rnd_d_rdata", bus.d_rdata, mrd);
    estall = (bus.i_req && !egi) || (bus.d_req && !egd) || (egd && !bus.d_we && mown != 2);
    chk("rnd_stall", 32'(core_stall), 32'(estall));
    chk("rnd_conflicts", 32'(perf_conflicts), 32'(mc));
    // advance
    mh = (sel != 0 && !bus.m_ready) ? sel : 0;
    if (!bus.i_req || egi) ms = 0;
    else if (bus.d_req && egd && ms < LIMIT) ms = ms + 1;
    if (bus.i_req && bus.d_req && mc < CMAX) mc = mc + 1;
    mown = egi ? 1 : ((egd && !bus.d_we) ? 2 : 0);
    mrd  = memf(ea);
  endtask

  initial begin
    logic        gi, gd, ib, db;
    logic [31:0] r;
    //                ir    ia            dr    dwe   da            dbe    mr    gi    gd    mreq  mwe   maddr         mbe    stall irv   drv   rdata          conf
    tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         8'd0};
    tbl[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         8'd0};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 32'h00500093,  8'd0};
    tbl[3]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,         8'd0};
    tbl[4]  = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104,  4'hF, 1'b0, 1'b0, 1'b1, 32'hA5A52000,  8'd1};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 32'hA5A50104,  8'd1};
    tbl[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h3000, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000, 4'h3, 1'b1, 1'b0, 1'b0, 32'h0,         8'd1};
    tbl[7]  = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h3000, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000, 4'h3, 1'b1, 1'b0, 1'b0, 32'h0,         8'd1};
    tbl[8]  = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h3000, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000, 4'h3, 1'b1, 1'b0, 1'b0, 32'h0,         8'd2};
    tbl[9]  = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h3000, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3000, 4'h3, 1'b1, 1'b0, 1'b0, 32'h0,         8'd3};
    tbl[10] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200,  4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         8'd4};
    tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 32'hA5A50200,  8'd4};

    // Reset held with both requests up: nothing may be granted or presented.
    apply(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1);
    bus.m_rdata = '0;
    #3;
    chk("rst_m_req", 32'(bus.m_req), 32'h0);
    chk("rst_i_gnt", 32'(bus.i_gnt), 32'h0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
    chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("rst_conflicts", 32'(perf_conflicts), 32'h0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int k = 0; k < 12; k++) begin
      apply(tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dwe, tbl[k].da, 32'h1234_5678, tbl[k].dbe, tbl[k].mr);
      #1;
      chk($sformatf("v%0d_i_gnt", k), 32'(bus.i_gnt), 32'(tbl[k].gi));
      chk($sformatf("v%0d_d_gnt", k), 32'(bus.d_gnt), 32'(tbl[k].gd));
      chk($sformatf("v%0d_m_req", k), 32'(bus.m_req), 32'(tbl[k].mreq));
      if (tbl[k].mreq) begin
        chk($sformatf("v%0d_m_we", k), 32'(bus.m_we), 32'(tbl[k].mwe));
        chk($sformatf("v%0d_m_addr", k), bus.m_addr, tbl[k].maddr);
        chk($sformatf("v%0d_m_be", k), 32'(bus.m_be), 32'(tbl[k].mbe));
      end
      chk($sformatf("v%0d_stall", k), 32'(core_stall), 32'(tbl[k].stall));
      chk($sformatf("v%0d_i_rvalid", k), 32'(bus.i_rvalid), 32'(tbl[k].irv));
      chk($sformatf("v%0d_d_rvalid", k), 32'(bus.d_rvalid), 32'(tbl[k].drv));
      if (tbl[k].irv) chk($sformatf("v%0d_i_rdata", k), bus.i_rdata, tbl[k].rdata);
      if (tbl[k].drv) chk($sformatf("v%0d_d_rdata", k), bus.d_rdata, tbl[k].rdata);
      chk($sformatf("v%0d_conflicts", k), 32'(perf_conflicts), 32'(tbl[k].conf));
      step();
    end

    // Fetch starvation bound: 4 data wins, then fetch, repeating.
    for (int c = 1; c <= 10; c++) begin
      apply(1'b1, 32'h400, 1'b1, 1'b0, 32'h5000 + 32'(4 * c), 32'h0, 4'hF, 1'b1);
      #1;
      chk($sformatf("starve_c%0d_i_gnt", c), 32'(bus.i_gnt), 32'((c == 5) || (c == 10)));
      chk($sformatf("starve_c%0d_d_gnt", c), 32'(bus.d_gnt), 32'(!((c == 5) || (c == 10))));
      step();
    end

    // Reset during a data hold: FSM back in IDLE, so a lone fetch wins at once.
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h7000, 32'h0, 4'hF, 1'b0);
    #1;
    chk("hold_m_addr", bus.m_addr, 32'h7000);
    rst_n = 1'b0;
    #1;
    chk("hold_rst_m_req", 32'(bus.m_req), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #1;
    chk("post_rst_i_gnt", 32'(bus.i_gnt), 32'h1);
    chk("post_rst_m_addr", bus.m_addr, 32'h800);
    chk("post_rst_d_gnt", 32'(bus.d_gnt), 32'h0);
    step();

    // Reset with a data read in flight: the return is dropped.
    apply(1'b1, 32'h900, 1'b1, 1'b0, 32'h7004, 32'h0, 4'hF, 1'b1);
    #1;
    chk("inflight_d_gnt", 32'(bus.d_gnt), 32'h1);
    pulse_reset();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #1;
    chk("inflight_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("inflight_i_rvalid", 32'(bus.i_rvalid), 32'h0);
    chk("inflight_conflicts", 32'(perf_conflicts), 32'h0);
    chk("inflight_m_req", 32'(bus.m_req), 32'h0);
    step();
    chk("inflight_d_rvalid2", 32'(bus.d_rvalid), 32'h0);

    // Conflict counter saturation over 2^CW + 5 contested cycles.
    for (int k = 0; k < (1 << CW) + 5; k++) begin
      apply(1'b1, 32'hA00, 1'b1, 1'b0, 32'hB00, 32'h0, 4'hF, 1'b0);
      #1;
      if (k == 250) chk("sat_count_250", 32'(perf_conflicts), 32'd250);
      step();
    end
    #1;
    chk("sat_all_ones", 32'(perf_conflicts), 32'(CMAX));

    // Random traffic against the reference model.
    pulse_reset();
    mh = 0; ms = 0; mc = 0; mown = 0; mrd = '0;
    ib = 1'b0; db = 1'b0;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    for (int k = 0; k < 600; k++) begin
      if (!ib || $urandom_range(0, 99) < 3) begin
        r = $urandom;
        bus.i_req  = ($urandom_range(0, 99) < 55);
        bus.i_addr = {r[31:2], 2'b00};
      end
      if (!db || $urandom_range(0, 99) < 3) begin
        bus.d_req   = ($urandom_range(0, 99) < 55);
        bus.d_we    = ($urandom_range(0, 99) < 40);
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_be    = 4'($urandom_range(1, 15));
      end
      bus.m_ready = ($urandom_range(0, 99) < 70);
      #1;
      mdl_cycle(gi, gd);
      ib = bus.i_req && !gi;
      db = bus.d_req && !gd;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
